nn_layer_sequencer: RTL and testbench
=====================================

# nn_layer_sequencer

Controller that drives the `nn` datapath through its layers. It accepts one 16-bit input sample per inference over a valid/ready handshake. It then drives `layer` from 0 to NUM_LAYERS-1, holding each index for HOLD_CYCLES clocks, with the sample held on `in`. It captures the final `out` value and returns it on a valid/ready result port.

## Interface
- NUM_LAYERS, 3, layers per inference; legal range 1..2**LAYER_W
- HOLD_CYCLES, 2, clocks each layer index is held; must be ≥1
- DATA_W, 16, width of sample, `nn` in/out and result
- LAYER_W, 3, width of layer index
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start_valid  in  1  input sample offered
- start_ready  out  1  sequencer can accept a sample
- start_data  in  DATA_W  input sample
- nn_layer  out  LAYER_W  layer index to `nn`
- nn_in  out  DATA_W  sample to `nn`
- nn_out  in  DATA_W  result from `nn`
- layer_start  out  1  one-cycle pulse on the first cycle of each layer
- busy  out  1  inference in progress (state RUN)
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  DATA_W  captured final `nn_out`

## Operation
- States: IDLE, RUN, DONE. Counters: layer_cnt (LAYER_W), hold_cnt (sized for HOLD_CYCLES-1).
- Transitions:
  - IDLE: start_ready=1. On start_valid&&start_ready, latch start_data into nn_in, set layer_cnt=0 and hold_cnt=0, then go to RUN.
  - RUN: hold_cnt increments each cycle. When hold_cnt==HOLD_CYCLES-1:
    - if layer_cnt<NUM_LAYERS-1: layer_cnt++ and hold_cnt=0.
    - else: capture nn_out into res_data and go to DONE.
  - DONE: res_valid=1. On res_valid&&res_ready, go to IDLE.
- Output decode:
  - start_ready = (state==IDLE). busy = (state==RUN). res_valid = (state==DONE). All are decoded from registered state.
  - nn_layer = layer_cnt in RUN and DONE. It is 0 in IDLE.
  - nn_in holds the latched sample from acceptance until the next acceptance. It is not cleared on return to IDLE.
  - res_data holds the last capture until the next capture.
  - layer_start = (state==RUN && hold_cnt==0), registered-state decode.
- start_valid is ignored outside IDLE; no queueing.
- res_data is stable while res_valid=1 and res_ready=0.
- No new start is accepted in the same cycle as a result handshake. IDLE is entered first, and the earliest acceptance is the following cycle.
- NUM_LAYERS=1: a single layer of HOLD_CYCLES clocks. HOLD_CYCLES=1: layer_start is high every RUN cycle.

## Timing
- Reset (rst_n low, asynchronous):
  - state=IDLE, counters=0, nn_in=0, res_data=0.
  - Outputs: start_ready=1, busy=0, res_valid=0, layer_start=0, nn_layer=0.
- Reset mid-RUN or mid-DONE aborts immediately; the in-flight result is lost. After release, the first rising edge behaves as IDLE.
- Start handshake at edge T gives RUN from cycle T+1, with nn_layer=0 and layer_start=1.
- Layer k is driven during cycles T+1+k·HOLD_CYCLES through T+(k+1)·HOLD_CYCLES.
- nn_out is sampled at the edge ending cycle T+NUM_LAYERS·HOLD_CYCLES, i.e. the last cycle of the last layer.
- res_valid=1 from cycle T+1+NUM_LAYERS·HOLD_CYCLES. With defaults, start at T gives res_valid at T+7.
- `nn` must present a settled out for the current layer by the last hold cycle of that layer.
- Minimum inference period: NUM_LAYERS·HOLD_CYCLES+2 cycles, with res_ready tied high.

## Test plan
- Reset then idle: assert rst_n=0 mid-cycle -> immediately start_ready=1, res_valid=0, nn_layer=0, res_data=0.
- Nominal run, defaults, `nn` model out=in+layer, start_data=16'h0003 at T -> nn_layer sequence 0,0,1,1,2,2; layer_start at T+1, T+3, T+5; res_valid at T+7 with res_data=16'h0005.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid -> res_data stable, start_valid ignored (start_ready=0); res_ready=1 gives IDLE next cycle.
- Back-to-back: res_ready=1 and start_valid=1 held continuously, samples 3 and 7 -> accepts 8 cycles apart, results 5 then 9, no start accepted on the result-handshake cycle.
- Reset mid-RUN at layer 1 -> outputs return to reset values asynchronously; after release a new sample 16'h0010 completes with res_data=16'h0012.
- Parameter corners: NUM_LAYERS=1, HOLD_CYCLES=1 -> res_valid one cycle after RUN entry; NUM_LAYERS=8, LAYER_W=3 -> nn_layer reaches 7 without wrap, result captured at layer 7.

Source files
------------

// File: rtl/nn_layer_sequencer.sv
// ============================================================================
//  Module      : nn_layer_sequencer
//  Description : Steps an external `nn` datapath through NUM_LAYERS layers,
//                holding each layer index for HOLD_CYCLES clocks with the
//                accepted sample on nn_in, then returns the final nn_out over
//                a valid/ready result port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nn_layer_sequencer #(
    parameter int NUM_LAYERS  = 3,
    parameter int HOLD_CYCLES = 2,
    parameter int DATA_W      = 16,
    parameter int LAYER_W     = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [DATA_W-1:0]  start_data,
    output logic [LAYER_W-1:0] nn_layer,
    output logic [DATA_W-1:0]  nn_in,
    input  logic [DATA_W-1:0]  nn_out,
    output logic               layer_start,
    output logic               busy,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [DATA_W-1:0]  res_data
);

    // Hold counter needs at least one bit even when each layer lasts one clock.
    localparam int                 HOLD_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [LAYER_W-1:0] LAYER_LAST = LAYER_W'(NUM_LAYERS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [LAYER_W-1:0]  r_layer_cnt;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [DATA_W-1:0]   r_nn_in;
    logic [DATA_W-1:0]   r_res_data;
    logic                r_start_ready;
    logic                r_busy;
    logic                r_res_valid;
    logic                r_layer_start;

    // Sequencer FSM; status outputs are registered alongside the state so they
    // always reflect the state the FSM is in during the current cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_layer_cnt   <= '0;
            r_hold_cnt    <= '0;
            r_nn_in       <= '0;
            r_res_data    <= '0;
            r_start_ready <= 1'b1;
            r_busy        <= 1'b0;
            r_res_valid   <= 1'b0;
            r_layer_start <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_valid && r_start_ready) begin
                        r_nn_in       <= start_data;
                        r_layer_cnt   <= '0;
                        r_hold_cnt    <= '0;
                        r_state       <= S_RUN;
                        r_start_ready <= 1'b0;
                        r_busy        <= 1'b1;
                        r_layer_start <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        if (r_layer_cnt < LAYER_LAST) begin
                            r_layer_cnt   <= r_layer_cnt + 1'b1;
                            r_hold_cnt    <= '0;
                            r_layer_start <= 1'b1;
                        end else begin
                            // Last hold cycle of the last layer: nn_out is settled.
                            r_res_data    <= nn_out;
                            r_state       <= S_DONE;
                            r_busy        <= 1'b0;
                            r_res_valid   <= 1'b1;
                            r_layer_start <= 1'b0;
                        end
                    end else begin
                        r_hold_cnt    <= r_hold_cnt + 1'b1;
                        r_layer_start <= 1'b0;
                    end
                end
                S_DONE: begin
                    // Returning to IDLE first keeps a start from landing on the
                    // result-handshake cycle; nn_layer drops back to 0 there.
                    if (r_res_valid && res_ready) begin
                        r_state       <= S_IDLE;
                        r_res_valid   <= 1'b0;
                        r_start_ready <= 1'b1;
                        r_layer_cnt   <= '0;
                        r_hold_cnt    <= '0;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_layer_cnt   <= '0;
                    r_hold_cnt    <= '0;
                    r_start_ready <= 1'b1;
                    r_busy        <= 1'b0;
                    r_res_valid   <= 1'b0;
                    r_layer_start <= 1'b0;
                end
            endcase
        end
    end

    assign start_ready = r_start_ready;
    assign busy        = r_busy;
    assign res_valid   = r_res_valid;
    assign layer_start = r_layer_start;
    assign nn_layer    = r_layer_cnt;
    assign nn_in       = r_nn_in;
    assign res_data    = r_res_data;

endmodule

`default_nettype wire

// File: tb/tb_nn_layer_sequencer.sv
// ============================================================================
//  Module      : tb_nn_layer_sequencer
//  Description : Self-checking bench for nn_layer_sequencer. Three instances
//                (default, 1 layer x 1 clock, 8 layers x 2 clocks) share the
//                stimulus; each is compared every cycle with a reference model
//                that tracks elapsed cycles since acceptance.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nn_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_valid = 1'b0;
    logic [15:0] start_data = '0;
    logic        res_ready = 1'b0;

    logic        sr0, bz0, rv0, ls0;
    logic [2:0]  ly0;
    logic [15:0] ni0, no0, rd0;
    logic        sr1, bz1, rv1, ls1;
    logic [2:0]  ly1;
    logic [15:0] ni1, no1, rd1;
    logic        sr2, bz2, rv2, ls2;
    logic [2:0]  ly2;
    logic [15:0] ni2, no2, rd2;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state per instance
    int          P_N [3] = '{3, 1, 8};
    int          P_H [3] = '{2, 1, 2};
    int          m_st[3];   // 0 idle, 1 run, 2 done
    int          m_t [3];   // 1-based cycle number within the run
    logic [15:0] m_in[3];
    logic [15:0] m_res[3];

    always #5 clk = ~clk;

    // `nn` datapath stand-in: out = in + layer
    assign no0 = ni0 + {13'd0, ly0};
    assign no1 = ni1 + {13'd0, ly1};
    assign no2 = ni2 + {13'd0, ly2};

    nn_layer_sequencer #(.NUM_LAYERS(3), .HOLD_CYCLES(2), .DATA_W(16), .LAYER_W(3)) u0 (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(sr0),
        .start_data(start_data), .nn_layer(ly0), .nn_in(ni0), .nn_out(no0),
        .layer_start(ls0), .busy(bz0), .res_valid(rv0), .res_ready(res_ready),
        .res_data(rd0));

    nn_layer_sequencer #(.NUM_LAYERS(1), .HOLD_CYCLES(1), .DATA_W(16), .LAYER_W(3)) u1 (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(sr1),
        .start_data(start_data), .nn_layer(ly1), .nn_in(ni1), .nn_out(no1),
        .layer_start(ls1), .busy(bz1), .res_valid(rv1), .res_ready(res_ready),
        .res_data(rd1));

    nn_layer_sequencer #(.NUM_LAYERS(8), .HOLD_CYCLES(2), .DATA_W(16), .LAYER_W(3)) u2 (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(sr2),
        .start_data(start_data), .nn_layer(ly2), .nn_in(ni2), .nn_out(no2),
        .layer_start(ls2), .busy(bz2), .res_valid(rv2), .res_ready(res_ready),
        .res_data(rd2));

    task automatic chk(input string tag, input int i, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s inst%0d t=%0t: got %0h expected %0h", tag, i, $time, got, exp);
        end
    endtask

    task automatic check_inst(input int i, input logic sr, input logic bz, input logic rv,
                              input logic ls, input logic [2:0] ly,
                              input logic [15:0] ni, input logic [15:0] rd);
        int exp_layer;
        bit exp_ls;
        exp_layer = 0;
        exp_ls    = 1'b0;
        if (m_st[i] == 1) begin
            exp_layer = (m_t[i] - 1) / P_H[i];
            exp_ls    = ((m_t[i] - 1) % P_H[i]) == 0;
        end else if (m_st[i] == 2) begin
            exp_layer = P_N[i] - 1;
        end
        chk("start_ready", i, {31'd0, sr}, (m_st[i] == 0) ? 32'd1 : 32'd0);
        chk("busy",        i, {31'd0, bz}, (m_st[i] == 1) ? 32'd1 : 32'd0);
        chk("res_valid",   i, {31'd0, rv}, (m_st[i] == 2) ? 32'd1 : 32'd0);
        chk("layer_start", i, {31'd0, ls}, {31'd0, exp_ls});
        chk("nn_layer",    i, {29'd0, ly}, exp_layer);
        chk("nn_in",       i, {16'd0, ni}, {16'd0, m_in[i]});
        chk("res_data",    i, {16'd0, rd}, {16'd0, m_res[i]});
    endtask

    task automatic check_all();
        check_inst(0, sr0, bz0, rv0, ls0, ly0, ni0, rd0);
        check_inst(1, sr1, bz1, rv1, ls1, ly1, ni1, rd1);
        check_inst(2, sr2, bz2, rv2, ls2, ly2, ni2, rd2);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_st[i]  = 0;
            m_t[i]   = 0;
            m_in[i]  = '0;
            m_res[i] = '0;
        end
    endtask

    // Advance the model by one clock given the inputs held during this cycle.
    task automatic model_advance(input logic sv, input logic [15:0] sd, input logic rr);
        for (int i = 0; i < 3; i++) begin
            case (m_st[i])
                0: if (sv) begin
                       m_st[i] = 1;
                       m_t[i]  = 1;
                       m_in[i] = sd;
                   end
                1: if (m_t[i] == P_N[i] * P_H[i]) begin
                       m_res[i] = m_in[i] + 16'(P_N[i] - 1);
                       m_st[i]  = 2;
                   end else begin
                       m_t[i] = m_t[i] + 1;
                   end
                default: if (rr) m_st[i] = 0;
            endcase
        end
    endtask

    // One clock: drive inputs, check current outputs, advance model, move to next negedge.
    task automatic step(input logic sv, input logic [15:0] sd, input logic rr);
        start_valid = sv;
        start_data  = sd;
        res_ready   = rr;
        check_all();
        model_advance(sv, sd, rr);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Reset while idle
        async_reset();
        step(1'b0, 16'h0000, 1'b1);

        // Nominal inference with sample 3
        step(1'b1, 16'h0003, 1'b1);
        for (int k = 0; k < 8; k++) step(1'b0, 16'($urandom), 1'b0);
        chk("nominal_res", 0, {16'd0, rd0}, 32'h0005);
        for (int k = 0; k < 12; k++) step(1'b0, 16'($urandom), 1'b1);

        // Backpressure: starts offered while results are held
        step(1'b1, 16'h0041, 1'b0);
        for (int k = 0; k < 24; k++) step(1'b1, 16'($urandom), 1'b0);
        step(1'b0, 16'h0000, 1'b1);
        step(1'b0, 16'h0000, 1'b1);

        // Back-to-back with start_valid and res_ready held high
        step(1'b1, 16'h0003, 1'b1);
        for (int k = 0; k < 7; k++) step(1'b1, 16'h0007, 1'b1);
        for (int k = 0; k < 9; k++) step(1'b1, 16'h0007, 1'b1);
        chk("b2b_res", 0, {16'd0, rd0}, 32'h0009);
        for (int k = 0; k < 20; k++) step(1'b1, 16'($urandom), 1'b1);
        step(1'b0, 16'h0000, 1'b1);
        for (int k = 0; k < 20; k++) step(1'b0, 16'h0000, 1'b1);

        // Reset during layer 1, then a fresh inference with 0x10
        step(1'b1, 16'h0022, 1'b1);
        step(1'b0, 16'h0000, 1'b1);
        step(1'b0, 16'h0000, 1'b1);
        async_reset();
        step(1'b1, 16'h0010, 1'b0);
        for (int k = 0; k < 18; k++) step(1'b0, 16'h0000, 1'b0);
        chk("post_reset_res", 0, {16'd0, rd0}, 32'h0012);
        chk("corner8_res",    2, {16'd0, rd2}, 32'h0017);
        step(1'b0, 16'h0000, 1'b1);

        // Randomised traffic
        for (int k = 0; k < 400; k++)
            step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 3) != 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
